// File: rtl/apostas_truco.sv
`default_nettype none
// ============================================================================
//  Module      : apostas_truco
//  Description : Hand-stake controller for the truco scoreboard. Tracks the
//                value of the current hand (1, 3, 6, 9, 12) through calls,
//                accepts, counter-raises and folds. It pays a decided hand as
//                a train of single-cycle ponto_a/ponto_b pulses, one per
//                point, with each pulse followed by GAP low cycles.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                pede_a, pede_b       - truco call / raise (rising edge)
//                aceita, corre        - responder accepts / folds (rising edge)
//                vence_a, vence_b     - hand won (rising edge)
//                jogo_encerrado       - game over from the scoreboard (level)
//                valor_mao, proposta  - accepted / pending hand value
//                pendente, quem_pediu - call pending, pending caller (0=A)
//                ponto_a, ponto_b     - payout pulses
//                ocupado, encerrado   - payout in progress, block frozen
//  Revision    : 1.0 - initial release
// ============================================================================
module apostas_truco #(
    parameter int GAP = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pede_a,
    input  logic       pede_b,
    input  logic       aceita,
    input  logic       corre,
    input  logic       vence_a,
    input  logic       vence_b,
    input  logic       jogo_encerrado,
    output logic [3:0] valor_mao,
    output logic [3:0] proposta,
    output logic       pendente,
    output logic       quem_pediu,
    output logic       ponto_a,
    output logic       ponto_b,
    output logic       ocupado,
    output logic       encerrado
);

    localparam int              c_GW       = (GAP < 1) ? 1 : $clog2(GAP + 1);
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP);

    localparam logic [1:0] S_JOGANDO  = 2'd0;
    localparam logic [1:0] S_PENDENTE = 2'd1;
    localparam logic [1:0] S_PAGANDO  = 2'd2;
    localparam logic [1:0] S_FIM      = 2'd3;

    localparam logic [1:0] c_DONO_NONE = 2'd0;
    localparam logic [1:0] c_DONO_A    = 2'd1;
    localparam logic [1:0] c_DONO_B    = 2'd2;

    // Raise ladder; 12 (and any unexpected value) maps to itself.
    function automatic logic [3:0] f_next(input logic [3:0] v);
        case (v)
            4'd1:    f_next = 4'd3;
            4'd3:    f_next = 4'd6;
            4'd6:    f_next = 4'd9;
            4'd9:    f_next = 4'd12;
            default: f_next = v;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [5:0]      r_prev;      // {pede_a, pede_b, aceita, corre, vence_a, vence_b}
    logic [1:0]      r_dono;
    logic [3:0]      r_pay_cnt;   // points still to pay, including current one
    logic [c_GW-1:0] r_phase;     // 0 = pulse cycle, 1..GAP = gap cycles
    logic            r_team;      // team being paid (0 = A)

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic [5:0] w_in;
    logic [5:0] w_edge;
    logic       w_pa, w_pb, w_ac, w_co, w_va, w_vb;

    assign w_in   = {pede_a, pede_b, aceita, corre, vence_a, vence_b};
    assign w_edge = w_in & ~r_prev;
    assign {w_pa, w_pb, w_ac, w_co, w_va, w_vb} = w_edge;

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    logic [1:0]      w_state_nxt;
    logic [3:0]      w_valor_nxt;
    logic [3:0]      w_prop_nxt;
    logic            w_quem_nxt;
    logic [1:0]      w_dono_nxt;
    logic [3:0]      w_cnt_nxt;
    logic [c_GW-1:0] w_phase_nxt;
    logic            w_team_nxt;
    logic            w_resp_pede;
    logic [1:0]      w_caller_dono;

    // The responder is the team opposite to the pending caller.
    assign w_resp_pede   = quem_pediu ? w_pa : w_pb;
    assign w_caller_dono = quem_pediu ? c_DONO_B : c_DONO_A;

    always_comb begin
        w_state_nxt = r_state;
        w_valor_nxt = valor_mao;
        w_prop_nxt  = proposta;
        w_quem_nxt  = quem_pediu;
        w_dono_nxt  = r_dono;
        w_cnt_nxt   = r_pay_cnt;
        w_phase_nxt = r_phase;
        w_team_nxt  = r_team;

        case (r_state)
            S_JOGANDO: begin
                if (w_va ^ w_vb) begin
                    w_state_nxt = S_PAGANDO;
                    w_cnt_nxt   = valor_mao;
                    w_phase_nxt = '0;
                    w_team_nxt  = w_vb;
                end else if (!(w_va || w_vb) && (w_pa ^ w_pb)) begin
                    // A team may not raise its own accepted raise.
                    if ((valor_mao < 4'd12) &&
                        (r_dono != (w_pb ? c_DONO_B : c_DONO_A))) begin
                        w_state_nxt = S_PENDENTE;
                        w_prop_nxt  = f_next(valor_mao);
                        w_quem_nxt  = w_pb;
                    end
                end
            end

            S_PENDENTE: begin
                if (w_co) begin
                    // Fold pays the caller the pre-raise value.
                    w_state_nxt = S_PAGANDO;
                    w_cnt_nxt   = valor_mao;
                    w_phase_nxt = '0;
                    w_team_nxt  = quem_pediu;
                    w_prop_nxt  = 4'd0;
                end else if (w_ac) begin
                    w_state_nxt = S_JOGANDO;
                    w_valor_nxt = proposta;
                    w_dono_nxt  = w_caller_dono;
                    w_prop_nxt  = 4'd0;
                end else if (w_resp_pede && (proposta < 4'd12)) begin
                    // Counter-raise implicitly accepts the pending proposal.
                    w_valor_nxt = proposta;
                    w_prop_nxt  = f_next(proposta);
                    w_quem_nxt  = ~quem_pediu;
                    w_dono_nxt  = w_caller_dono;
                end
            end

            S_PAGANDO: begin
                if (r_phase == c_GAP_LAST) begin
                    w_phase_nxt = '0;
                    if (r_pay_cnt <= 4'd1) begin
                        w_state_nxt = S_JOGANDO;
                        w_cnt_nxt   = 4'd0;
                        w_valor_nxt = 4'd1;
                        w_dono_nxt  = c_DONO_NONE;
                        w_prop_nxt  = 4'd0;
                    end else begin
                        w_cnt_nxt = r_pay_cnt - 4'd1;
                    end
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end

            default: begin
                // S_FIM: frozen until reset.
            end
        endcase

        // Game over overrides every event in every state.
        if (jogo_encerrado) begin
            w_state_nxt = S_FIM;
            w_prop_nxt  = 4'd0;
        end
    end

    // ------------------------------------------------------------------
    // Output logic: decoded from the next state so outputs are registered
    // and change together with the state.
    // ------------------------------------------------------------------
    logic w_pendente_nxt;
    logic w_ocupado_nxt;
    logic w_ponto_a_nxt;
    logic w_ponto_b_nxt;
    logic w_encerrado_nxt;

    always_comb begin
        w_pendente_nxt  = (w_state_nxt == S_PENDENTE);
        w_ocupado_nxt   = (w_state_nxt == S_PAGANDO);
        w_encerrado_nxt = (w_state_nxt == S_FIM);
        w_ponto_a_nxt   = w_ocupado_nxt && (w_phase_nxt == '0) && !w_team_nxt;
        w_ponto_b_nxt   = w_ocupado_nxt && (w_phase_nxt == '0) &&  w_team_nxt;
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_JOGANDO;
            r_prev     <= '0;
            r_dono     <= c_DONO_NONE;
            r_pay_cnt  <= 4'd0;
            r_phase    <= '0;
            r_team     <= 1'b0;
            valor_mao  <= 4'd1;
            proposta   <= 4'd0;
            quem_pediu <= 1'b0;
            pendente   <= 1'b0;
            ocupado    <= 1'b0;
            ponto_a    <= 1'b0;
            ponto_b    <= 1'b0;
            encerrado  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= w_in;
            r_dono     <= w_dono_nxt;
            r_pay_cnt  <= w_cnt_nxt;
            r_phase    <= w_phase_nxt;
            r_team     <= w_team_nxt;
            valor_mao  <= w_valor_nxt;
            proposta   <= w_prop_nxt;
            quem_pediu <= w_quem_nxt;
            pendente   <= w_pendente_nxt;
            ocupado    <= w_ocupado_nxt;
            ponto_a    <= w_ponto_a_nxt;
            ponto_b    <= w_ponto_b_nxt;
            encerrado  <= w_encerrado_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apostas_truco.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apostas_truco
//  Description : Directed self-checking bench for apostas_truco (GAP = 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apostas_truco;

    localparam logic [5:0] c_PA = 6'b100000;
    localparam logic [5:0] c_PB = 6'b010000;
    localparam logic [5:0] c_AC = 6'b001000;
    localparam logic [5:0] c_CO = 6'b000100;
    localparam logic [5:0] c_VA = 6'b000010;
    localparam logic [5:0] c_VB = 6'b000001;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] stim;
    logic       jogo;
    logic [3:0] valor_mao, proposta;
    logic       pendente, quem_pediu, ponto_a, ponto_b, ocupado, encerrado;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    apostas_truco #(.GAP(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .pede_a        (stim[5]),
        .pede_b        (stim[4]),
        .aceita        (stim[3]),
        .corre         (stim[2]),
        .vence_a       (stim[1]),
        .vence_b       (stim[0]),
        .jogo_encerrado(jogo),
        .valor_mao     (valor_mao),
        .proposta      (proposta),
        .pendente      (pendente),
        .quem_pediu    (quem_pediu),
        .ponto_a       (ponto_a),
        .ponto_b       (ponto_b),
        .ocupado       (ocupado),
        .encerrado     (encerrado)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an event mask for one clock edge, then release it.
    task automatic fire(input logic [5:0] m);
        stim = m;
        tick();
        stim = '0;
    endtask

    // Sample n consecutive cycles starting with the current one.
    task automatic capture(input int n, output logic [63:0] ma, output logic [63:0] mb,
                           output int occ);
        ma  = '0;
        mb  = '0;
        occ = 0;
        for (int i = 0; i < n; i++) begin
            ma[i] = ponto_a;
            mb[i] = ponto_b;
            occ  += int'(ocupado);
            tick();
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valor"},     64'(valor_mao),  64'd1);
        chk({tag, "_proposta"},  64'(proposta),   64'd0);
        chk({tag, "_pendente"},  64'(pendente),   64'd0);
        chk({tag, "_quem"},      64'(quem_pediu), 64'd0);
        chk({tag, "_pontos"},    64'({ponto_a, ponto_b}), 64'd0);
        chk({tag, "_ocupado"},   64'(ocupado),    64'd0);
        chk({tag, "_encerrado"}, 64'(encerrado),  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] ma, mb;
        int          occ;
        logic [5:0]  masks [7];
        logic        acc;

        rst  = 1'b1;
        stim = '0;
        jogo = 1'b0;
        tick();
        tick();
        chk_reset("rst0");
        rst = 1'b0;
        tick();

        // 1: single point to A
        fire(c_VA);
        chk("t1_valor_during", 64'(valor_mao), 64'd1);
        capture(6, ma, mb, occ);
        chk("t1_mask_a", ma, 64'h1);
        chk("t1_mask_b", mb, 64'h0);
        chk("t1_ocupado", 64'(occ), 64'd4);
        chk("t1_valor_after", 64'(valor_mao), 64'd1);

        // 2: truco accepted, B wins 3 points
        fire(c_PA); tick();
        chk("t2_pend", 64'(pendente), 64'd1);
        chk("t2_prop", 64'(proposta), 64'd3);
        chk("t2_quem", 64'(quem_pediu), 64'd0);
        fire(c_AC); tick();
        chk("t2_valor", 64'(valor_mao), 64'd3);
        chk("t2_prop_clr", 64'(proposta), 64'd0);
        fire(c_VB);
        capture(14, ma, mb, occ);
        chk("t2_mask_b", mb, 64'h111);
        chk("t2_mask_a", ma, 64'h0);
        chk("t2_ocupado", 64'(occ), 64'd12);
        chk("t2_valor_after", 64'(valor_mao), 64'd1);
        fire(c_PA); tick();
        chk("t2_dono_clr", 64'(pendente), 64'd1);
        fire(c_CO);
        capture(6, ma, mb, occ);
        chk("t2_fold_a", ma, 64'h1);

        // 3: counter-raise then fold
        fire(c_PA); tick();
        fire(c_PB); tick();
        chk("t3_valor", 64'(valor_mao), 64'd3);
        chk("t3_prop", 64'(proposta), 64'd6);
        chk("t3_quem", 64'(quem_pediu), 64'd1);
        chk("t3_pend", 64'(pendente), 64'd1);
        fire(c_CO);
        capture(14, ma, mb, occ);
        chk("t3_mask_b", mb, 64'h111);
        chk("t3_mask_a", ma, 64'h0);

        // 4: ladder to 12
        fire(c_PA); tick(); fire(c_AC); tick();
        fire(c_PA); tick();
        chk("t4_self_raise_ign", 64'(pendente), 64'd0);
        fire(c_PB); tick(); fire(c_AC); tick();
        fire(c_PA); tick(); fire(c_AC); tick();
        fire(c_PB); tick(); fire(c_AC); tick();
        chk("t4_valor12", 64'(valor_mao), 64'd12);
        fire(c_PA); tick();
        chk("t4_past12_pend", 64'(pendente), 64'd0);
        chk("t4_past12_prop", 64'(proposta), 64'd0);
        fire(c_VA);
        capture(50, ma, mb, occ);
        chk("t4_mask_a", ma, 64'h111111111111);
        chk("t4_ocupado", 64'(occ), 64'd48);

        // 5: simultaneous events
        fire(c_PA | c_PB); tick();
        chk("t5_dual_pede", 64'(pendente), 64'd0);
        fire(c_VA | c_VB);
        capture(6, ma, mb, occ);
        chk("t5_dual_vence", {ma[31:0], mb[31:0]}, 64'h0);
        chk("t5_dual_vence_occ", 64'(occ), 64'd0);
        fire(c_PB); tick();
        fire(c_CO | c_AC);
        capture(6, ma, mb, occ);
        chk("t5_corre_wins", mb, 64'h1);
        chk("t5_corre_valor", 64'(valor_mao), 64'd1);
        fire(c_VA);
        chk("t5_pay_pulse", 64'(ponto_a), 64'd1);
        tick();
        fire(6'b111111);
        capture(8, ma, mb, occ);
        chk("t5_ign_pulses", {ma[31:0], mb[31:0]}, 64'h0);
        chk("t5_ign_occ", 64'(occ), 64'd2);
        chk("t5_ign_pend", 64'(pendente), 64'd0);

        // 6a: game over mid-train
        fire(c_PA); tick(); fire(c_AC); tick();
        fire(c_PB); tick(); fire(c_AC); tick();
        chk("t6_valor6", 64'(valor_mao), 64'd6);
        fire(c_VB);
        capture(8, ma, mb, occ);
        chk("t6_first2", mb, 64'h11);
        chk("t6_pulse2", 64'(ponto_b), 64'd1);
        jogo = 1'b1;
        tick();
        chk("t6_stop", 64'({ponto_a, ponto_b, ocupado}), 64'd0);
        chk("t6_enc", 64'(encerrado), 64'd1);
        masks = '{c_PA, c_PB, c_AC, c_CO, c_VA, c_VB, c_VA | c_PB};
        acc = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) jogo = 1'b0;
            fire(masks[i]);
            acc |= ponto_a | ponto_b | pendente | ocupado;
            tick();
        end
        chk("t6_frozen_act", 64'(acc), 64'd0);
        chk("t6_frozen_enc", 64'(encerrado), 64'd1);
        chk("t6_frozen_valor", 64'(valor_mao), 64'd6);

        // 6b: reset while a call is pending
        rst = 1'b1; tick(); rst = 1'b0; tick();
        fire(c_PA); tick();
        chk("t6b_pend", 64'(pendente), 64'd1);
        rst = 1'b1;
        tick();
        chk_reset("t6b_rst");
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
